// File: rtl/secded_pkg.sv
// SEC-DED (72,64) shared definitions.
// Code layout, error classes and pipeline bundles.
package secded_pkg;

    localparam int DATA_W = 64;
    localparam int CODE_W = 72;
    localparam int SYND_W = 7;

    localparam int PAR_POS = 0;
    localparam int CHK_POS [SYND_W] = '{1, 2, 4, 8, 16, 32, 64};

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_CE,
        ERR_UE
    } err_t;

    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] code;
        logic [SYND_W-1:0] synd;
        logic              par;
    } s1_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        err_t              err;
        logic [SYND_W-1:0] pos;
    } s2_t;

    function automatic logic is_chk(input int i);
        is_chk = 1'b0;
        for (int k = 0; k < SYND_W; k++) begin
            if (CHK_POS[k] == i) is_chk = 1'b1;
        end
    endfunction

    function automatic int data_pos(input int j);
        int n;
        data_pos = 0;
        n = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if (!is_chk(i)) begin
                if (n == j) data_pos = i;
                n++;
            end
        end
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Hamming syndrome and overall parity of a 72-bit codeword.
// Pure combinational; shared with the encoder.
module secded_syndrome
    import secded_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYND_W-1:0] synd,
    output logic              par
);

    // s[k] folds every position whose index has bit k set
    always_comb begin
        synd = '0;
        for (int k = 0; k < SYND_W; k++) begin
            for (int i = 0; i < CODE_W; i++) begin
                if (((i >> k) & 1) == 1) synd[k] = synd[k] ^ code[i];
            end
        end
        par = ^code;
    end

endmodule

// File: rtl/secded_checker.sv
// SEC-DED (72,64) checker: 2-stage decode/correct pipeline
// with error flags, saturating counters and first-error log.
module secded_checker
    import secded_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [71:0]       IN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [63:0]       OUT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              ERR_CE,
    output logic              ERR_UE,
    output logic [6:0]        ERR_POS,
    input  logic              CNT_CLR,
    output logic [CNT_W-1:0]  CE_COUNT,
    output logic [CNT_W-1:0]  UE_COUNT,
    output logic              LOG_VALID,
    output logic              LOG_UE,
    output logic [7:0]        LOG_SYND
);

    logic              en;
    logic              fire;
    logic [SYND_W-1:0] synd;
    logic              par;
    s1_t               s1;
    s2_t               s2;
    err_t              err_c;
    logic [CODE_W-1:0] flip_c;
    logic [CODE_W-1:0] fixed_c;
    logic [DATA_W-1:0] data_c;
    logic              is_ce;
    logic              is_ue;
    logic [CNT_W-1:0]  ce_cnt;
    logic [CNT_W-1:0]  ue_cnt;
    logic              log_v;
    logic              log_ue;
    logic [7:0]        log_s;
    logic [7:0]        s2_synd;

    secded_syndrome u_synd (
        .code (IN),
        .synd (synd),
        .par  (par)
    );

    assign en       = !s2.valid || OUT_READY;
    assign IN_READY = en;
    assign fire     = s2.valid && OUT_READY;

    // stage 1: capture codeword with its syndrome and parity
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
        end else if (en) begin
            s1.valid <= IN_VALID;
            s1.code  <= IN;
            s1.synd  <= synd;
            s1.par   <= par;
        end
    end

    // classify the stage-1 beat from syndrome and parity
    always_comb begin
        err_c = secded_pkg::ERR_NONE;
        if (s1.par) begin
            if (int'(s1.synd) < CODE_W) err_c = secded_pkg::ERR_CE;
            else                        err_c = secded_pkg::ERR_UE;
        end else if (s1.synd != '0) begin
            err_c = secded_pkg::ERR_UE;
        end
    end

    // flip the flagged position only for a correctable error
    always_comb begin
        flip_c = '0;
        if (err_c == secded_pkg::ERR_CE) begin
            flip_c = {{(CODE_W-1){1'b0}}, 1'b1} << s1.synd;
        end
        fixed_c = s1.code ^ flip_c;
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_ext
        assign data_c[j] = fixed_c[data_pos(j)];
    end

    // stage 2: corrected data, error class, position, syndrome
    always_ff @(posedge clk) begin
        if (rst) begin
            s2      <= '0;
            s2_synd <= '0;
        end else if (en) begin
            s2.valid <= s1.valid;
            s2.data  <= data_c;
            s2.err   <= s1.valid ? err_c : secded_pkg::ERR_NONE;
            s2.pos   <= (err_c == secded_pkg::ERR_CE) ? s1.synd : '0;
            s2_synd  <= {s1.par, s1.synd};
        end
    end

    assign is_ce = s2.valid && (s2.err == secded_pkg::ERR_CE);
    assign is_ue = s2.valid && (s2.err == secded_pkg::ERR_UE);

    assign OUT       = s2.data;
    assign OUT_VALID = s2.valid;
    assign ERR_CE    = is_ce;
    assign ERR_UE    = is_ue;
    assign ERR_POS   = is_ce ? s2.pos : '0;

    // saturating error counters; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || CNT_CLR) begin
            ce_cnt <= '0;
            ue_cnt <= '0;
        end else if (fire) begin
            if (is_ce && ce_cnt != '1) ce_cnt <= ce_cnt + 1'b1;
            if (is_ue && ue_cnt != '1) ue_cnt <= ue_cnt + 1'b1;
        end
    end

    // first-error log, sticky until cleared
    always_ff @(posedge clk) begin
        if (rst || CNT_CLR) begin
            log_v  <= 1'b0;
            log_ue <= 1'b0;
            log_s  <= '0;
        end else if (fire && (is_ce || is_ue) && !log_v) begin
            log_v  <= 1'b1;
            log_ue <= is_ue;
            log_s  <= s2_synd;
        end
    end

    assign CE_COUNT  = ce_cnt;
    assign UE_COUNT  = ue_cnt;
    assign LOG_VALID = log_v;
    assign LOG_UE    = log_ue;
    assign LOG_SYND  = log_s;

endmodule

// File: tb/tb_secded_checker.sv
// Directed bench for secded_checker: decode classes,
// backpressure, saturation, clear and reset behaviour.
module tb_secded_checker;

    logic        clk;
    logic        rst;
    logic [71:0] IN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [63:0] OUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        ERR_CE;
    logic        ERR_UE;
    logic [6:0]  ERR_POS;
    logic        CNT_CLR;
    logic [15:0] CE_COUNT;
    logic [15:0] UE_COUNT;
    logic        LOG_VALID;
    logic        LOG_UE;
    logic [7:0]  LOG_SYND;

    logic        in_ready4;
    logic [63:0] out4;
    logic        out_valid4;
    logic        err_ce4;
    logic        err_ue4;
    logic [6:0]  err_pos4;
    logic [3:0]  ce_count4;
    logic [3:0]  ue_count4;
    logic        log_valid4;
    logic        log_ue4;
    logic [7:0]  log_synd4;

    int tests = 0;
    int fails = 0;

    secded_checker dut (
        .clk       (clk),
        .rst       (rst),
        .IN        (IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ERR_CE    (ERR_CE),
        .ERR_UE    (ERR_UE),
        .ERR_POS   (ERR_POS),
        .CNT_CLR   (CNT_CLR),
        .CE_COUNT  (CE_COUNT),
        .UE_COUNT  (UE_COUNT),
        .LOG_VALID (LOG_VALID),
        .LOG_UE    (LOG_UE),
        .LOG_SYND  (LOG_SYND)
    );

    secded_checker #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .IN        (IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (in_ready4),
        .OUT       (out4),
        .OUT_VALID (out_valid4),
        .OUT_READY (OUT_READY),
        .ERR_CE    (err_ce4),
        .ERR_UE    (err_ue4),
        .ERR_POS   (err_pos4),
        .CNT_CLR   (CNT_CLR),
        .CE_COUNT  (ce_count4),
        .UE_COUNT  (ue_count4),
        .LOG_VALID (log_valid4),
        .LOG_UE    (log_ue4),
        .LOG_SYND  (log_synd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [71:0] obs,
                       input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one isolated beat, OUT_READY held high; checks OUT two edges after accept
    task automatic beat(input string tag,
                        input logic [71:0] c,
                        input logic [63:0] d,
                        input logic ce,
                        input logic ue,
                        input logic [6:0] pos);
        IN = c;
        IN_VALID = 1'b1;
        chk({tag, "_rdy"}, IN_READY, 1'b1);
        @(posedge clk); #1;
        IN_VALID = 1'b0;
        chk({tag, "_lat1"}, OUT_VALID, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, OUT_VALID, 1'b1);
        chk({tag, "_out"}, OUT, d);
        chk({tag, "_ce"}, ERR_CE, ce);
        chk({tag, "_ue"}, ERR_UE, ue);
        chk({tag, "_pos"}, ERR_POS, pos);
        @(posedge clk); #1;
    endtask

    logic [71:0] src_tab [4];
    logic [63:0] exp_tab [4];
    int          src;
    int          rcv;
    logic        held;
    logic [63:0] held_val;

    initial begin
        src_tab[0] = 72'h0F; exp_tab[0] = 64'h1;
        src_tab[1] = 72'h33; exp_tab[1] = 64'h2;
        src_tab[2] = 72'h55; exp_tab[2] = 64'h4;
        src_tab[3] = 72'h96; exp_tab[3] = 64'h8;

        rst = 1'b1;
        IN = '0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        CNT_CLR = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ovld", OUT_VALID, 1'b0);
        chk("rst_out", OUT, 64'h0);
        chk("rst_ce", ERR_CE, 1'b0);
        chk("rst_ue", ERR_UE, 1'b0);
        chk("rst_cecnt", CE_COUNT, 16'h0);
        chk("rst_uecnt", UE_COUNT, 16'h0);
        chk("rst_log", LOG_VALID, 1'b0);
        chk("rst_rdy", IN_READY, 1'b1);

        beat("zero", 72'h0, 64'h0, 1'b0, 1'b0, 7'd0);
        chk("zero_cecnt", CE_COUNT, 16'd0);
        chk("zero_uecnt", UE_COUNT, 16'd0);
        chk("zero_log", LOG_VALID, 1'b0);

        beat("ce3", 72'h8, 64'h0, 1'b1, 1'b0, 7'd3);
        chk("ce3_cnt", CE_COUNT, 16'd1);
        chk("ce3_logv", LOG_VALID, 1'b1);
        chk("ce3_logs", LOG_SYND, 8'h83);
        chk("ce3_logue", LOG_UE, 1'b0);

        beat("ue35", 72'h28, 64'h3, 1'b0, 1'b1, 7'd0);
        chk("ue35_cnt", UE_COUNT, 16'd1);
        chk("ue35_logs", LOG_SYND, 8'h83);
        chk("ue35_logue", LOG_UE, 1'b0);

        beat("clean1", 72'h0F, 64'h1, 1'b0, 1'b0, 7'd0);
        beat("fix_d0", 72'h07, 64'h1, 1'b1, 1'b0, 7'd3);
        beat("ce71", 72'h1 << 71, 64'h0, 1'b1, 1'b0, 7'd71);
        beat("ce0", 72'h1, 64'h0, 1'b1, 1'b0, 7'd0);
        chk("ce_cnt4", CE_COUNT, 16'd4);

        beat("ue127", (72'h1 << 71) | (72'h1 << 40) | (72'h1 << 16),
             64'h8000_0002_0000_0000, 1'b0, 1'b1, 7'd0);
        beat("ue72", (72'h1 << 64) | 72'h100, 64'h0, 1'b0, 1'b1, 7'd0);
        chk("ue_cnt3", UE_COUNT, 16'd3);

        src = 0;
        rcv = 0;
        held = 1'b0;
        held_val = '0;
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            OUT_READY = !(cyc >= 3 && cyc <= 5);
            IN_VALID = (src < 4);
            IN = (src < 4) ? src_tab[src] : 72'h0;
            @(negedge clk);
            if (OUT_VALID && !OUT_READY) chk("bp_rdy_low", IN_READY, 1'b0);
            if (held) chk("bp_stable", OUT, held_val);
            held = OUT_VALID && !OUT_READY;
            held_val = OUT;
            if (OUT_VALID && OUT_READY) begin
                if (rcv < 4) chk("bp_data", OUT, exp_tab[rcv]);
                rcv++;
            end
            if (IN_VALID && IN_READY) src++;
            @(posedge clk); #1;
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        chk("bp_count", rcv, 4);
        chk("bp_nodup", OUT_VALID, 1'b0);

        IN = 72'h8;
        IN_VALID = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat16", CE_COUNT, 16'd20);
        chk("sat4", ce_count4, 4'hF);
        chk("sat4_ue", ue_count4, 4'd3);

        IN = 72'h8;
        IN_VALID = 1'b1;
        @(posedge clk); #1;
        IN_VALID = 1'b0;
        @(posedge clk); #1;
        chk("clr_ce", ERR_CE, 1'b1);
        CNT_CLR = 1'b1;
        @(posedge clk); #1;
        CNT_CLR = 1'b0;
        chk("clr_cnt16", CE_COUNT, 16'd0);
        chk("clr_cnt4", ce_count4, 4'd0);
        chk("clr_ue16", UE_COUNT, 16'd0);
        chk("clr_log", LOG_VALID, 1'b0);
        chk("clr_log4", log_valid4, 1'b0);

        beat("ue_post", 72'h28, 64'h3, 1'b0, 1'b1, 7'd0);
        chk("post_uecnt", UE_COUNT, 16'd1);
        chk("post_logv", LOG_VALID, 1'b1);
        chk("post_logue", LOG_UE, 1'b1);
        chk("post_logs", LOG_SYND, 8'h06);

        OUT_READY = 1'b0;
        IN = 72'h33;
        IN_VALID = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("full_vld", OUT_VALID, 1'b1);
        chk("full_rdy", IN_READY, 1'b0);
        rst = 1'b1;
        IN_VALID = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_ovld", OUT_VALID, 1'b0);
        chk("mrst_out", OUT, 64'h0);
        chk("mrst_uecnt", UE_COUNT, 16'd0);
        chk("mrst_log", LOG_VALID, 1'b0);
        chk("mrst_rdy", IN_READY, 1'b1);
        OUT_READY = 1'b1;
        @(posedge clk); #1;
        chk("mrst_drop", OUT_VALID, 1'b0);

        beat("after_rst", 72'h96, 64'h8, 1'b0, 1'b0, 7'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/secded_checker.md
Name: secded_checker

Overview:
- Receiving end of the 72-bit SEC-DED path: takes (72,64) codewords, possibly corrupted by the fault injector, and returns corrected 64-bit data.
- 2-stage pipeline with valid/ready handshake on both sides.
- Per-beat error flags, saturating correctable/uncorrectable counters, and a first-error log.
- Sits between the fault injector output and the cache data consumer.

Parameters:
CNT_W, 16, width of the CE and UE counters (saturating).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
IN  input  72  codeword, bit i = code position i
IN_VALID  input  1  codeword valid
IN_READY  output  1  checker accepts codeword this cycle
OUT  output  64  corrected data
OUT_VALID  output  1  output beat valid
OUT_READY  input  1  consumer accepts beat
ERR_CE  output  1  beat on OUT had a corrected single-bit error
ERR_UE  output  1  beat on OUT is uncorrectable; OUT is uncorrected raw data
ERR_POS  output  7  code position corrected (valid when ERR_CE)
CNT_CLR  input  1  clears counters and log
CE_COUNT  output  CNT_W  accepted beats with ERR_CE
UE_COUNT  output  CNT_W  accepted beats with ERR_UE
LOG_VALID  output  1  log holds an error
LOG_UE  output  1  logged error was uncorrectable
LOG_SYND  output  8  logged {overall parity, syndrome[6:0]}

Behaviour:
- Code layout:
  - Position 0 is the overall parity bit.
  - Positions 1, 2, 4, 8, 16, 32, 64 are Hamming check bits.
  - Data bits d[0..63] fill the remaining positions 3, 5, 6, 7, 9, ... 71, in ascending order.
- Decode:
  - s[k] = XOR of IN[i] over all i with bit k of i set (k = 0..6).
  - p = XOR of all 72 bits.
- Classification:
  - s=0, p=0: clean.
  - p=1, s<=71: CE at position s. s=0 means the parity bit itself is in error and the data is unchanged.
  - p=1, s>71: UE.
  - s!=0, p=0: UE (double error).
- Pipeline:
  - Global advance en = !OUT_VALID || OUT_READY.
  - IN_READY = en (combinational).
  - Stage 1 registers the codeword, s, p and the stage valid bit.
  - Stage 2 registers the corrected data and flags.
  - Latency is 2 cycles from IN accept to OUT_VALID with no stall. Throughput is 1 beat/cycle.
  - While en=0, both stages hold. OUT and the flags stay stable while OUT_VALID && !OUT_READY.
  - Bubbles propagate: a stage valid bit loads 0 when the upstream stage is invalid.
- Correction: OUT = data extracted after flipping code position s when CE. On UE, OUT is the unmodified extracted data.
- ERR_CE, ERR_UE and ERR_POS are 0 when OUT_VALID=0.
- Counters:
  - Increment on an OUT_VALID && OUT_READY beat with the matching flag.
  - Saturate at all-ones, with no wrap.
  - CNT_CLR in the same cycle as an increment: clear wins, result 0.
- Log:
  - On the first accepted error beat while LOG_VALID=0, capture LOG_UE and LOG_SYND, then set LOG_VALID.
  - The log holds until CNT_CLR or rst; later errors are ignored.
  - CNT_CLR coincident with an error beat: the log is cleared, not captured.
- Reset (any cycle, including mid-stream): both stage valids, OUT_VALID, OUT, all flags, counters and the log go to 0; in-flight beats are dropped. IN_READY=1 in the cycle after reset.

Decomposition:
- secded_pkg holds:
  - constants DATA_W=64, CODE_W=72, SYND_W=7;
  - check-bit position constants;
  - function data_pos(j) returning the code position of data bit j;
  - enum err_t {ERR_NONE, ERR_CE, ERR_UE}.
- One combinational sub-module, secded_syndrome (72-bit in, s[6:0] and p out). It is shared with a future encoder.

Test Plan:
- All-zero codeword, OUT_READY=1 -> OUT=64'h0 two cycles later, ERR_CE=0, ERR_UE=0, counters 0.
- IN with only bit 3 set -> OUT=64'h0, ERR_CE=1, ERR_POS=3, CE_COUNT=1, LOG_SYND=8'h83, LOG_UE=0.
- IN with bits 3 and 5 set -> ERR_UE=1, OUT=64'h3 (d0, d1 raw), UE_COUNT=1. The log keeps the earlier CE entry.
- Backpressure: stream 4 beats, OUT_READY low for 3 cycles mid-stream -> IN_READY drops, OUT stable, all 4 beats are delivered in order with none lost or duplicated.
- CNT_W=4, 20 accepted CE beats -> CE_COUNT=15. CNT_CLR together with an error beat -> count 0, LOG_VALID=0.
- rst asserted with both stages full -> next cycle OUT_VALID=0, counters 0, IN_READY=1; the first post-reset beat appears 2 cycles after acceptance.
